dcache_ctrl: RTL

//  Responder end of the dcache request interface driven by the memory stage.

---
 rtl/dcache_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through dcache responder, one 64-bit word per line.
// Read misses and all writes go to a single-word backing-memory bus.
module dcache_ctrl #(
    parameter int INDEX_BITS = 6,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             dcache_en,
    input  logic             dcache_wren,
    input  logic [63:0]      dcache_addr,
    input  logic [63:0]      dcache_wdata,
    output logic [63:0]      dcache_rdata,
    output logic             dcache_done,
    input  logic             inv_all,
    output logic             mem_req,
    output logic             mem_we,
    output logic [63:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    input  logic [63:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int NL = 1 << INDEX_BITS;
    localparam int TW = 64 - INDEX_BITS - 3;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] RESP   = 3'd2;
    localparam logic [2:0] MEM_RD = 3'd3;
    localparam logic [2:0] MEM_WR = 3'd4;

    logic [2:0]            state;
    logic [63:3]           req_word;
    logic                  req_wren;
    logic [63:0]           req_wdata;
    logic [NL-1:0]         valid;
    logic [TW-1:0]         tag_mem  [NL];
    logic [63:0]           data_mem [NL];
    logic [INDEX_BITS-1:0] idx;
    logic [TW-1:0]         req_tag;
    logic                  hit;
    logic                  unused_addr_lsb;

    assign unused_addr_lsb = ^dcache_addr[2:0];
    assign idx     = req_word[INDEX_BITS+2:3];
    assign req_tag = req_word[63:INDEX_BITS+3];
    assign hit     = valid[idx] && (tag_mem[idx] == req_tag);
    assign dcache_done = (state == RESP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            req_word     <= '0;
            req_wren     <= 1'b0;
            req_wdata    <= '0;
            valid        <= '0;
            dcache_rdata <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // Invalidate lands before the lookup of a same-cycle request.
                    if (inv_all) valid <= '0;
                    if (dcache_en) begin
                        req_word     <= dcache_addr[63:3];
                        req_wren     <= dcache_wren;
                        req_wdata    <= dcache_wdata;
                        dcache_rdata <= '0;
                        state        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (req_wren) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {req_word, 3'b000};
                        mem_wdata <= req_wdata;
                        state     <= MEM_WR;
                    end else if (hit) begin
                        dcache_rdata <= data_mem[idx];
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        state <= RESP;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_word, 3'b000};
                        state    <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    if (mem_ack) begin
                        valid[idx]   <= 1'b1;
                        dcache_rdata <= mem_rdata;
                        mem_req      <= 1'b0;
                        state        <= RESP;
                    end
                end
                MEM_WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; the valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == LOOKUP && req_wren && hit)
            data_mem[idx] <= req_wdata;
        if (state == MEM_RD && mem_ack) begin
            tag_mem[idx]  <= req_tag;
            data_mem[idx] <= mem_rdata;
        end
    end
endmodule
